// File: rtl/inv_set_columns_if.sv
// inv_set_columns_if
// Groups the two valid/ready handshakes of the InvMixColumns engine.
//   in_valid / in_ready / in    : 128-bit state offered by the producer
//   out_valid / out_ready / Out : 128-bit result returned to the consumer
// The slave modport is the engine's view; the master modport is the
// producer/consumer environment that drives the state in and takes results.
interface inv_set_columns_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] Out;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in,
        output out_valid,
        input  out_ready,
        output Out
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in,
        input  out_valid,
        output out_ready,
        input  Out
    );
endinterface

// File: rtl/inv_set_columns.sv
// inv_set_columns
// Sequential AES InvMixColumns engine. A 128-bit state is captured on the
// input handshake, then one 32-bit column per clock is replaced in place by
// its inverse column mix using a single shared column datapath. After four
// CALC cycles the result is held on Out until the consumer takes it.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - inv_set_columns_if.slave (input and output handshakes)
//   busy - high while a state is being transformed or waiting for handoff
module inv_set_columns (
    input  logic             clk,
    input  logic             rst,
    inv_set_columns_if.slave bus,
    output logic             busy
);
    localparam int BYTE     = 8;
    localparam int WORD     = 32;
    localparam int SENTENCE = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [SENTENCE-1:0] st_q, st_d;
    logic [WORD-1:0]     col_in, col_out;

    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns {09*b, 0b*b, 0d*b, 0e*b} built from shared xtime powers.
    function automatic logic [WORD-1:0] inv_coeffs(input logic [BYTE-1:0] b);
        logic [BYTE-1:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return {x8 ^ b, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ x4 ^ x2};
    endfunction

    // One column: a0 is the MSB byte (row 0).
    function automatic logic [WORD-1:0] inv_mix_col(input logic [WORD-1:0] w);
        logic [WORD-1:0] m0, m1, m2, m3;
        logic [BYTE-1:0] r0, r1, r2, r3;
        m0 = inv_coeffs(w[31:24]);
        m1 = inv_coeffs(w[23:16]);
        m2 = inv_coeffs(w[15:8]);
        m3 = inv_coeffs(w[7:0]);
        // byte lanes of mN: [31:24]=09, [23:16]=0b, [15:8]=0d, [7:0]=0e
        r0 = m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24];
        r1 = m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8];
        r2 = m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16];
        r3 = m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0];
        return {r0, r1, r2, r3};
    endfunction

    // Column select feeding the single shared datapath; column 0 is the top word.
    always_comb begin
        col_in = st_q[127:96];
        case (col_q)
            2'd0:    col_in = st_q[127:96];
            2'd1:    col_in = st_q[95:64];
            2'd2:    col_in = st_q[63:32];
            default: col_in = st_q[31:0];
        endcase
        col_out = inv_mix_col(col_in);
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        st_d    = st_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d    = bus.in;
                    col_d   = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                case (col_q)
                    2'd0:    st_d[127:96] = col_out;
                    2'd1:    st_d[95:64]  = col_out;
                    2'd2:    st_d[63:32]  = col_out;
                    default: st_d[31:0]   = col_out;
                endcase
                // col wraps 3 -> 0 on the last write, ready for the next state
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            st_q    <= st_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Out       = st_q;
    assign busy          = (state_q == CALC) || (state_q == DONE);
endmodule

// File: tb/tb_inv_set_columns.sv
// tb_inv_set_columns
// Self-checking bench for inv_set_columns. Expected results come from a
// GF(2^8) matrix model (generic multiply by shift-and-add) of both the
// forward and the inverse column mix.
module tb_inv_set_columns;
    logic clk;
    logic rst;
    logic busy;
    int   n_vec;
    int   n_err;

    inv_set_columns_if bus ();

    inv_set_columns dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic GF(2^8) multiply with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // Circulant column mix: r_i = XOR_j coef[(j - i) mod 4] * a_j for each column.
    function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] coef);
        logic [127:0] r;
        logic [7:0]   acc;
        logic [7:0]   cf;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    cf  = coef[31 - 8 * ((j - i + 4) % 4) -: 8];
                    acc = acc ^ gmul(cf, s[127 - 32 * c - 8 * j -: 8]);
                end
                r[127 - 32 * c - 8 * i -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_model(input logic [127:0] s);
        return mix(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fwd_model(input logic [127:0] s);
        return mix(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full transaction with out_ready=1; ok=0 if the result never appears.
    task automatic run_txn(input logic [127:0] s, output logic [127:0] res, output bit ok);
        ok  = 1'b0;
        res = '0;
        bus.in        = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10 && !bus.in_ready; k++) tick();
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid) begin
                res = bus.Out;
                ok  = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.in        = rand128();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_flags got out_valid=%b busy=%b want 0 0", bus.out_valid, busy);
        end
        n_vec++;
        if (bus.Out !== 128'h0) begin
            n_err++;
            $display("[TB] FAIL reset_out got=%h want=0", bus.Out);
        end
    endtask

    // Fixed-vector check with cycle-exact latency and flag checks.
    task automatic check_vector(input string name, input logic [127:0] din, input logic [127:0] want);
        bus.in        = din;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL %s_idle_ready got=%b want=1", name, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in       = ~din;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_vec++;
            if (k < 4) begin
                if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL %s_calc_flags cyc=%0d got ov=%b ir=%b busy=%b want 0 0 1",
                             name, k, bus.out_valid, bus.in_ready, busy);
                end
            end else begin
                if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL %s_done_flags got ov=%b ir=%b want 1 0", name, bus.out_valid, bus.in_ready);
                end
                n_vec++;
                if (bus.Out !== want) begin
                    n_err++;
                    $display("[TB] FAIL %s_out got=%h want=%h", name, bus.Out, want);
                end
            end
        end
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL %s_handoff got ov=%b ir=%b busy=%b want 0 1 0", name, bus.out_valid, bus.in_ready, busy);
        end
    endtask

    task automatic test_fips();
        check_vector("fips", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                     128'hdb135345_f20a225c_01010101_c6c6c6c6);
    endtask

    task automatic test_second();
        check_vector("second", 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff,
                     128'h2d26314c_d4d4d4d5_00000000_ffffffff);
    endtask

    task automatic test_backpressure();
        logic [127:0] din;
        logic [127:0] want;
        bit           seen;
        din  = rand128();
        want = inv_model(din);
        seen = 1'b0;
        bus.in        = din;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("[TB] FAIL stall_timeout got out_valid=%b want=1", bus.out_valid);
        end
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in = rand128();
            tick();
            n_vec++;
            if (bus.Out !== want || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL stall_hold cyc=%0d got Out=%h ov=%b ir=%b want Out=%h ov=1 ir=0",
                         k, bus.Out, bus.out_valid, bus.in_ready, want);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL stall_release got ov=%b ir=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int spurious;
        spurious = 0;
        bus.in        = rand128();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.Out !== 128'h0) begin
            n_err++;
            $display("[TB] FAIL midreset_state got ir=%b ov=%b busy=%b Out=%h want 1 0 0 0",
                     bus.in_ready, bus.out_valid, busy, bus.Out);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.out_valid) spurious++;
        end
        n_vec++;
        if (spurious !== 0) begin
            n_err++;
            $display("[TB] FAIL midreset_spurious got=%0d pulses want=0", spurious);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig;
        logic [127:0] res;
        bit           ok;
        for (int v = 0; v < 200; v++) begin
            orig = rand128();
            run_txn(fwd_model(orig), res, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("[TB] FAIL round_trip_timeout v=%0d got no out_valid want result", v);
            end else if (res !== orig) begin
                n_err++;
                $display("[TB] FAIL round_trip v=%0d got=%h want=%h", v, res, orig);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] states [3];
        logic [127:0] exp_q [$];
        logic [127:0] want;
        int           acc_cyc [$];
        int           idx;
        int           results;
        bit           accepted;
        for (int i = 0; i < 3; i++) states[i] = rand128();
        idx     = 0;
        results = 0;
        bus.in        = states[0];
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && results < 3; cyc++) begin
            accepted = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back(inv_model(bus.in));
                accepted = 1'b1;
            end
            if (bus.out_valid) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                n_vec++;
                if (bus.Out !== want) begin
                    n_err++;
                    $display("[TB] FAIL b2b_out n=%0d got=%h want=%h", results, bus.Out, want);
                end
                results++;
            end
            tick();
            if (accepted) begin
                idx++;
                if (idx < 3) bus.in = states[idx];
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (results != 3 || acc_cyc.size() != 3) begin
            n_err++;
            $display("[TB] FAIL b2b_count got results=%0d accepts=%0d want 3 3", results, acc_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_vec++;
                if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
                    n_err++;
                    $display("[TB] FAIL b2b_spacing i=%0d got=%0d want=6", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        tick();
        test_reset();
        test_fips();
        test_second();
        test_backpressure();
        test_reset_mid();
        test_round_trip();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
